// File: rtl/fft16_output_serializer_pkg.sv
// Shared FFT constants, serializer state encoding and bit-reversal helper.
package fft_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = 16;
  localparam int unsigned AW    = $clog2(N);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Reverse the low aw bits of idx; bits above aw come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned aw);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < aw) r[5'(i)] = idx[5'(aw - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft16_output_serializer_if.sv
// Capture-side and stream-side handshake bundle of the output serializer.
interface fft16_output_serializer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 16
);
  localparam int unsigned AW = $clog2(N);

  logic                 cap_valid;
  logic                 cap_ready;
  logic [N*WIDTH-1:0]   yr_in;
  logic [N*WIDTH-1:0]   yi_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [AW-1:0]        out_addr;
  logic [WIDTH-1:0]     yr_out;
  logic [WIDTH-1:0]     yi_out;
  logic                 out_last;
  logic                 busy;

  // Serializer view.
  modport slave (
    input  cap_valid, yr_in, yi_in, out_ready,
    output cap_ready, out_valid, out_addr, yr_out, yi_out, out_last, busy
  );

  // Producer/consumer view.
  modport master (
    output cap_valid, yr_in, yi_in, out_ready,
    input  cap_ready, out_valid, out_addr, yr_out, yi_out, out_last, busy
  );
endinterface

// File: rtl/fft16_output_serializer_bank.sv
// N-entry complex register file: frame-wide load, one indexed read port.
module fft_capture_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [N*WIDTH-1:0]     i_yr,
  input  logic [N*WIDTH-1:0]     i_yi,
  input  logic [$clog2(N)-1:0]   i_raddr,
  output logic [WIDTH-1:0]       o_yr,
  output logic [WIDTH-1:0]       o_yi
);

  logic [WIDTH-1:0] r_yr [N];
  logic [WIDTH-1:0] r_yi [N];

  // Whole-frame capture; reset clears every slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N); i++) begin
        r_yr[i] <= '0;
        r_yi[i] <= '0;
      end
    end else if (i_load) begin
      for (int i = 0; i < int'(N); i++) begin
        r_yr[i] <= i_yr[i*WIDTH +: WIDTH];
        r_yi[i] <= i_yi[i*WIDTH +: WIDTH];
      end
    end
  end

  assign o_yr = r_yr[i_raddr];
  assign o_yi = r_yi[i_raddr];

endmodule

// File: rtl/fft16_output_serializer.sv
// Captures one FFT result frame and streams it out one bin per beat.
module fft16_output_serializer #(
  parameter int unsigned WIDTH       = fft_pkg::WIDTH,
  parameter int unsigned N           = fft_pkg::N,
  parameter int unsigned BIT_REVERSE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  fft16_output_serializer_if.slave      bus
);
  import fft_pkg::*;

  localparam int unsigned AW = $clog2(N);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_raddr;
  logic          w_load;
  logic          w_cap_ready;
  logic          w_out_valid;
  logic          w_last;

  // State and bin counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter and handshake decode; last-beat handshake may reload in place.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_cap_ready = 1'b0;
    w_out_valid = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cap_ready = 1'b1;
        if (bus.cap_valid) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        w_out_valid = 1'b1;
        w_last      = (r_cnt == AW'(N - 1));
        if (bus.out_ready) begin
          if (!w_last) begin
            w_cnt_nxt = r_cnt + AW'(1);
          end else begin
            w_cap_ready = 1'b1;
            w_cnt_nxt   = '0;
            if (bus.cap_valid) w_load = 1'b1;
            else               w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_raddr = (BIT_REVERSE != 0) ? AW'(bitrev(32'(r_cnt), AW)) : r_cnt;

  fft_capture_bank #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_yr    (bus.yr_in),
    .i_yi    (bus.yi_in),
    .i_raddr (w_raddr),
    .o_yr    (bus.yr_out),
    .o_yi    (bus.yi_out)
  );

  assign bus.cap_ready = w_cap_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_addr  = r_cnt;
  assign bus.out_last  = w_last;
  assign bus.busy      = (r_state == STREAM);

endmodule

// File: tb/tb_fft16_output_serializer.sv
// Bench for fft16_output_serializer: natural-order and bit-reversed instances side by side.
module tb_fft16_output_serializer;

  localparam int NB = 16;
  localparam int WD = 16;

  typedef struct {
    int          addr;
    logic [15:0] yr;
    logic [15:0] yi;
  } beat_t;

  logic clk;
  logic rst;
  logic cap_valid;
  logic out_ready;
  logic [NB*WD-1:0] yr_v;
  logic [NB*WD-1:0] yi_v;

  int n_checks = 0;
  int n_errors = 0;
  int caps = 0;
  int pops = 0;
  int vcyc = 0;
  int hs = 0;
  int lasts0 = 0;

  beat_t q0[$];
  beat_t q1[$];
  logic [15:0] log0[$];
  logic [15:0] log1[$];

  int exp_br[16] = '{1, 9, 5, 13, 3, 11, 7, 15, 2, 10, 6, 14, 4, 12, 8, 16};

  fft16_output_serializer_if #(.WIDTH(WD), .N(NB)) if0 ();
  fft16_output_serializer_if #(.WIDTH(WD), .N(NB)) if1 ();

  assign if0.cap_valid = cap_valid;
  assign if0.out_ready = out_ready;
  assign if0.yr_in     = yr_v;
  assign if0.yi_in     = yi_v;
  assign if1.cap_valid = cap_valid;
  assign if1.out_ready = out_ready;
  assign if1.yr_in     = yr_v;
  assign if1.yi_in     = yi_v;

  fft16_output_serializer #(.WIDTH(WD), .N(NB), .BIT_REVERSE(0)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  fft16_output_serializer #(.WIDTH(WD), .N(NB), .BIT_REVERSE(1)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev4(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) r = r | (((k >> b) & 1) << (3 - b));
    return r;
  endfunction

  // Frame loader: slot i gets yr = rb + i, yi = ib + is*i.
  task automatic set_frame(input int rb, input int ib, input int is);
    for (int i = 0; i < NB; i++) begin
      yr_v[i*WD +: WD] = 16'(rb + i);
      yi_v[i*WD +: WD] = 16'(ib + is * i);
    end
  endtask

  // Reference model: every accepted frame becomes N queued beats in natural bin order.
  always @(posedge clk or negedge rst) begin
    logic crdy;
    if (!rst) begin
      q0.delete();
      q1.delete();
    end else begin
      crdy = (q0.size() == 0) || (out_ready && (q0[0].addr == NB - 1));
      if (q0.size() != 0 && out_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        pops++;
      end
      if (cap_valid && crdy) begin
        for (int k = 0; k < NB; k++) begin
          q0.push_back('{k, yr_v[k*WD +: WD], yi_v[k*WD +: WD]});
          q1.push_back('{k, yr_v[rev4(k)*WD +: WD], yi_v[rev4(k)*WD +: WD]});
        end
        caps++;
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (q0.size() != 0) begin
        check("d0_valid", 32'(if0.out_valid), 32'(1));
        check("d0_addr", 32'(if0.out_addr), 32'(q0[0].addr));
        check("d0_yr", 32'(if0.yr_out), 32'(q0[0].yr));
        check("d0_yi", 32'(if0.yi_out), 32'(q0[0].yi));
        check("d0_last", 32'(if0.out_last), 32'(q0[0].addr == NB - 1));
        check("d0_busy", 32'(if0.busy), 32'(1));
        check("d0_cap_ready", 32'(if0.cap_ready), 32'(out_ready && q0[0].addr == NB - 1));
      end else begin
        check("d0_valid", 32'(if0.out_valid), 32'(0));
        check("d0_cap_ready", 32'(if0.cap_ready), 32'(1));
        check("d0_busy", 32'(if0.busy), 32'(0));
      end
      if (q1.size() != 0) begin
        check("d1_valid", 32'(if1.out_valid), 32'(1));
        check("d1_addr", 32'(if1.out_addr), 32'(q1[0].addr));
        check("d1_yr", 32'(if1.yr_out), 32'(q1[0].yr));
        check("d1_yi", 32'(if1.yi_out), 32'(q1[0].yi));
        check("d1_last", 32'(if1.out_last), 32'(q1[0].addr == NB - 1));
        check("d1_cap_ready", 32'(if1.cap_ready), 32'(out_ready && q1[0].addr == NB - 1));
      end else begin
        check("d1_valid", 32'(if1.out_valid), 32'(0));
        check("d1_cap_ready", 32'(if1.cap_ready), 32'(1));
      end
      if (if0.out_valid) vcyc++;
      if (if0.out_valid && out_ready) begin
        hs++;
        log0.push_back(if0.yr_out);
        log1.push_back(if1.yr_out);
        if (if0.out_last) lasts0++;
      end
    end
  end

  task automatic clear_stats();
    vcyc = 0;
    hs = 0;
    lasts0 = 0;
    log0.delete();
    log1.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || if0.out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check(name, 32'(0), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d0_cap_ready"}, 32'(if0.cap_ready), 32'(1));
    check({tag, "_d0_valid"}, 32'(if0.out_valid), 32'(0));
    check({tag, "_d0_addr"}, 32'(if0.out_addr), 32'(0));
    check({tag, "_d0_yr"}, 32'(if0.yr_out), 32'(0));
    check({tag, "_d0_yi"}, 32'(if0.yi_out), 32'(0));
    check({tag, "_d0_last"}, 32'(if0.out_last), 32'(0));
    check({tag, "_d0_busy"}, 32'(if0.busy), 32'(0));
    check({tag, "_d1_cap_ready"}, 32'(if1.cap_ready), 32'(1));
    check({tag, "_d1_valid"}, 32'(if1.out_valid), 32'(0));
    check({tag, "_d1_yr"}, 32'(if1.yr_out), 32'(0));
    check({tag, "_d1_yi"}, 32'(if1.yi_out), 32'(0));
  endtask

  initial begin
    int base;
    rst = 1'b0;
    cap_valid = 1'b0;
    out_ready = 1'b0;
    yr_v = '0;
    yi_v = '0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // Single frame, ready held high: natural and bit-reversed orders.
    clear_stats();
    set_frame(1, -1, -1);
    out_ready = 1'b1;
    cap_valid = 1'b1;
    @(posedge clk);
    #1 cap_valid = 1'b0;
    wait_idle("t_single", 40);
    check("nat_beats", 32'(log0.size()), 32'(16));
    check("nat_last_count", 32'(lasts0), 32'(1));
    check("nat_cycles", 32'(vcyc), 32'(16));
    if (log0.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check("nat_lit_yr", 32'(log0[i]), 32'(i + 1));
        check("br_lit_yr", 32'(log1[i]), 32'(exp_br[i]));
      end
    end

    // Random backpressure; cap_valid held until the frame is recaptured on the last handshake.
    clear_stats();
    set_frame(50, 7, 3);
    base = caps;
    cap_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
      if (caps >= base + 2) cap_valid = 1'b0;
      if (caps >= base + 2 && q0.size() == 0) break;
    end
    check("bp_captures", 32'(caps - base), 32'(2));
    out_ready = 1'b1;
    wait_idle("t_backpressure", 40);
    check("bp_beats", 32'(hs), 32'(32));
    check("bp_last_count", 32'(lasts0), 32'(2));

    // Back-to-back frames with no bubble.
    clear_stats();
    set_frame(1, -1, -1);
    base = caps;
    out_ready = 1'b1;
    cap_valid = 1'b1;
    for (int c = 0; c < 60 && caps < base + 2; c++) begin
      @(posedge clk);
      #1;
      if (caps == base + 1) set_frame(100, 200, 1);
    end
    cap_valid = 1'b0;
    wait_idle("t_b2b", 60);
    check("b2b_captures", 32'(caps - base), 32'(2));
    check("b2b_cycles", 32'(vcyc), 32'(32));
    check("b2b_beats", 32'(hs), 32'(32));
    if (log0.size() >= 18) begin
      check("b2b_d0_bin16", 32'(log0[16]), 32'(100));
      check("b2b_d0_bin17", 32'(log0[17]), 32'(101));
      check("b2b_d1_bin17", 32'(log1[17]), 32'(108));
    end

    // Mid-stream reset after beat 5.
    set_frame(1, -1, -1);
    base = pops;
    cap_valid = 1'b1;
    @(posedge clk);
    #1 cap_valid = 1'b0;
    for (int c = 0; c < 40 && pops < base + 6; c++) begin
      @(posedge clk);
      #1;
    end
    check("mid_progress", 32'(pops - base), 32'(6));
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_cap_ready", 32'(if0.cap_ready), 32'(1));
    clear_stats();
    set_frame(100, 200, 1);
    @(posedge clk);
    #1 cap_valid = 1'b1;
    @(posedge clk);
    #1 cap_valid = 1'b0;
    wait_idle("t_after_rst", 40);
    check("after_rst_beats", 32'(log0.size()), 32'(16));
    if (log0.size() >= 1) check("after_rst_first_yr", 32'(log0[0]), 32'(100));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft16_output_serializer.md
# fft16_output_serializer

Output-side counterpart of the FFT input buffer: captures one complete 16-bin result frame from the flattened FFT stage buses in a single cycle, then streams it out one complex bin per beat over a valid/ready interface, in natural frequency order. It sits between the final FFT stage and any downstream consumer (UART bridge, magnitude unit, testbench monitor). It applies bit-reversal reordering optionally, so the FFT core can stay decimation-in-time with bit-reversed output.

## Interface
- `WIDTH`, 16: bits per real or imaginary sample, two's complement.
- `N`, 16: points per frame. Must be a power of two and ≥2. `AW = $clog2(N)`.
- `BIT_REVERSE`, 1: when 1, the beat for bin k reads capture slot bitrev(k). When 0, it reads slot k.

- `clk`  in  1  single clock; every register samples on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cap_valid`  in  1  a frame is present on `yr_in`/`yi_in`.
- `cap_ready`  out  1  serializer can accept a frame this cycle.
- `yr_in`  in  N*WIDTH  real parts; slot i is at `[(i+1)*WIDTH-1 : i*WIDTH]`.
- `yi_in`  in  N*WIDTH  imaginary parts; same packing as `yr_in`.
- `out_valid`  out  1  beat present on the output.
- `out_ready`  in  1  consumer accepts the beat.
- `out_addr`  out  AW  bin index k of the current beat.
- `yr_out`  out  WIDTH  real part of bin k.
- `yi_out`  out  WIDTH  imaginary part of bin k.
- `out_last`  out  1  high when k = N-1.
- `busy`  out  1  high while in STREAM.

## Operation
- States are IDLE and STREAM. The state and the bin counter `cnt` (AW bits) are registers.
- IDLE:
  - `cap_ready`=1, `out_valid`=0.
  - On `cap_valid`&`cap_ready`: latch all N real and N imaginary slots into the capture bank, set `cnt`=0, go to STREAM.
- STREAM:
  - `out_valid`=1, `out_addr`=`cnt`.
  - `yr_out`/`yi_out` = bank[BIT_REVERSE ? bitrev(cnt) : cnt].
  - `out_last` = (`cnt`==N-1).
- On each accepted beat (`out_valid`&`out_ready`):
  - if not last: `cnt` increments.
  - if last: go to IDLE, or stay in STREAM if a new frame is captured in the same cycle (see below).
- Stall: while `out_ready`=0, `out_valid`, `out_addr`, data and `out_last` hold stable. The bank is not written during STREAM except on the back-to-back case.
- `cap_ready` = IDLE | (`out_valid`&`out_ready`&`out_last`). This is a combinational path from `out_ready`.
- Back-to-back: a capture coincident with the last-beat handshake reloads the bank, sets `cnt`=0 and stays in STREAM. No idle bubble.
- `cap_valid` while `cap_ready`=0 is ignored. The producer must hold the frame.
- No arithmetic: data passes bit-exact. `cnt` wraps from N-1 only by leaving or restarting STREAM.
- Reset (any time, including mid-stream): state=IDLE, `cnt`=0, bank cleared to 0. The partial frame is discarded.

## Timing
- Reset values: `cap_ready`=1, `out_valid`=0, `out_addr`=0, `yr_out`=0, `yi_out`=0, `out_last`=0, `busy`=0.
- Capture at edge t gives `out_valid`=1 with bin 0 in the cycle after t.
- With `out_ready` held high, a frame drains in exactly N cycles, one bin per cycle.
- Throughput with continuous `cap_valid` and `out_ready`: one frame every N cycles.
- Output data is a mux of registered bank and `cnt`. There is no combinational path from `yr_in`/`yi_in` to the outputs.

## Structure
- Shared package `fft_pkg` holds:
  - `WIDTH`, `N`, `AW` constants;
  - the state enum {IDLE, STREAM};
  - a `bitrev(idx, AW)` function, also used by the FFT core.
- One natural sub-module: `fft_capture_bank`, the N×2×WIDTH register file with frame-wide load and one indexed read port. FSM and counter stay in the top.

## Test plan
- Reset/idle: hold `rst`=0, then release → `cap_ready`=1, `out_valid`=0, all outputs 0.
- Natural order, BIT_REVERSE=0: slot i = (yr=i+1, yi=-(i+1)), `out_ready`=1 → 16 consecutive beats, `out_addr` 0..15, yr 1..16, `out_last` only on beat 15, then IDLE.
- Bit-reverse, BIT_REVERSE=1, same frame → beats yr = 1,9,5,13,3,11,7,15,2,10,6,14,4,12,8,16 with `out_addr` 0..15.
- Backpressure: `out_ready` pseudo-random ~50% → every beat held stable while stalled, no bin skipped or duplicated, `cap_valid` ignored until the last handshake.
- Back-to-back: second frame (yr=100+i) presented with `cap_valid` held high → captured on the last-beat handshake, bin 0 (yr=100) appears the next cycle with no gap, 32 beats in 32 cycles.
- Mid-stream reset: assert `rst`=0 after beat 5 → `out_valid`=0 immediately (asynchronous), bank 0, `cap_ready`=1 after release. A new frame then streams from bin 0.
